// File: rtl/sram_pkg.sv
// sram_pkg: definitions shared by the SRAM request controller, the cell array
// and the bench.
//   state_t - controller FSM state encoding
//   row_w   - row-select width for a given row count
//   col_w   - column-group select width for a given row width and word width
//   addr_w  - full word-address width (row bits above column-group bits)
package sram_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  function automatic int row_w(input int rows);
    return $clog2(rows);
  endfunction

  function automatic int col_w(input int cols, input int data_width);
    return $clog2(cols / data_width);
  endfunction

  function automatic int addr_w(input int rows, input int cols, input int data_width);
    return row_w(rows) + col_w(cols, data_width);
  endfunction

endpackage

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: request/response front end directly upstream of the SRAM
// cell array. It takes word read/write requests, splits the word address
// into row and column group, drives the array select/enable/data lines,
// registers read data and returns it on a response handshake. After each
// reset it can sweep the whole array with zeros before accepting traffic.
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_we               1 = write, 0 = read
//   req_addr             word address {row, column group}
//   req_wmask/req_wdata  per-bit write enable and write data
//   rsp_valid/rsp_ready  read-response handshake
//   rsp_rdata            read data, held while rsp_valid && !rsp_ready
//   init_done            sticky flag: zero-fill sweep finished
//   arr_row/arr_col      array row_select / col_select
//   arr_we/arr_wdata     array write_enable / data_in
//   arr_rdata            array data_out (combinational from selected cells)
//   state_dbg            current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The sender holds valid (and its payload) until that edge; ready
// may come and go independently of valid. req_ready is high only in IDLE.
// rsp_valid is raised after a READ and stays high, with rsp_rdata frozen,
// until the edge where rsp_ready is seen high.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int  ROWS          = 64,
  parameter int  COLS          = 64,
  parameter int  DATA_WIDTH    = 8,
  parameter bit  INIT_ON_RESET = 1'b1,
  localparam int WORDS         = ROWS * COLS / DATA_WIDTH,
  localparam int ROW_W         = row_w(ROWS),
  localparam int COL_W         = col_w(COLS, DATA_WIDTH),
  localparam int ADDR_W        = addr_w(ROWS, COLS, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ROW_W-1:0]      arr_row,
  output logic [COL_W-1:0]      arr_col,
  output logic [DATA_WIDTH-1:0] arr_we,
  output logic [DATA_WIDTH-1:0] arr_wdata,
  input  logic [DATA_WIDTH-1:0] arr_rdata,
  output state_t                state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam state_t            RST_STATE = INIT_ON_RESET ? S_INIT : S_IDLE;

  state_t                state;
  logic [ADDR_W-1:0]     init_cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wmask_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign req_ready = (state == S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RST_STATE;
      init_cnt  <= '0;
      addr_q    <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= !INIT_ON_RESET;
    end else begin
      case (state)
        S_INIT: begin
          // One word per cycle; the counter wraps back to 0 after the last
          // word, so it is already clean if the sweep ever reruns.
          init_cnt <= init_cnt + ADDR_W'(1);
          if (init_cnt == LAST_WORD) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wmask_q <= req_wmask;
            wdata_q <= req_wdata;
            state   <= req_we ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        S_READ: begin
          rsp_rdata <= arr_rdata;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= RST_STATE;
        end
      endcase
    end
  end

  // Array drive. The select lines follow the registered address except during
  // the sweep. The sweep write enable is qualified with rst so the array is
  // never written while reset is held, even though the FSM already sits in
  // INIT; this lets word 0 be written in the very first cycle after release.
  always_comb begin
    arr_row   = addr_q[ADDR_W-1:COL_W];
    arr_col   = addr_q[COL_W-1:0];
    arr_we    = '0;
    arr_wdata = '0;
    case (state)
      S_INIT: begin
        arr_row = init_cnt[ADDR_W-1:COL_W];
        arr_col = init_cnt[COL_W-1:0];
        arr_we  = rst ? {DATA_WIDTH{1'b1}} : '0;
      end
      S_WRITE: begin
        arr_we    = wmask_q;
        arr_wdata = wdata_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed bench for sram_req_ctrl with default parameters
// (64x64 array, 8-bit words, 512 words, zero-fill sweep enabled).
// A behavioural cell array sits on the arr_* bus; cells that were never
// written read back a nonzero junk pattern so a missing sweep shows up.
module tb_sram_req_ctrl;
  import sram_pkg::*;

  localparam int DW     = 8;
  localparam int AW     = 9;
  localparam int WORDS  = 512;
  localparam int ROW_W  = 6;
  localparam int COL_W  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wmask = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [ROW_W-1:0] arr_row;
  logic [COL_W-1:0] arr_col;
  logic [DW-1:0] arr_we;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_rdata;
  state_t        state_dbg;

  sram_req_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wmask (req_wmask),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .arr_row   (arr_row),
    .arr_col   (arr_col),
    .arr_we    (arr_we),
    .arr_wdata (arr_wdata),
    .arr_rdata (arr_rdata),
    .state_dbg (state_dbg)
  );

  // ---------------- behavioural cell array ----------------
  bit [DW-1:0] mem     [WORDS];
  bit          written [WORDS];
  logic [AW-1:0] arr_idx;

  function automatic logic [DW-1:0] junk(input logic [AW-1:0] idx);
    return DW'(idx * 37) ^ 8'hA5 | 8'h01;
  endfunction

  assign arr_idx   = {arr_row, arr_col};
  assign arr_rdata = written[arr_idx] ? mem[arr_idx] : junk(arr_idx);

  always_ff @(posedge clk) begin
    if (|arr_we) begin
      mem[arr_idx]     <= (arr_rdata & ~arr_we) | (arr_wdata & arr_we);
      written[arr_idx] <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks are entered just after a falling edge and return just after one.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " accepted"}, 32'(req_ready), 32'd1);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    int ready_seen = 0;
    while (!init_done && n < 600) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (req_ready && !init_done) ready_seen++;
      if (n == 100) begin
        chk({tag, " sweep we"},    32'(arr_we),    32'hFF);
        chk({tag, " sweep addr"},  32'(arr_idx),   32'd100);
        chk({tag, " sweep wdata"}, 32'(arr_wdata), 32'd0);
      end
    end
    chk({tag, " init cycles"},      32'(n),          32'd512);
    chk({tag, " ready during init"}, 32'(ready_seen), 32'd0);
    chk({tag, " init_done"},        32'(init_done),  32'd1);
    chk({tag, " ready after init"}, 32'(req_ready),  32'd1);
    chk({tag, " idle we"},          32'(arr_we),     32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] m,
                          input logic [DW-1:0] d, input string tag);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    wait_ready(tag);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = DW'($urandom_range(0, 255));
    chk({tag, " write state"}, 32'(state_dbg), 32'(S_WRITE));
    chk({tag, " write addr"},  32'(arr_idx),   32'(a));
    chk({tag, " write we"},    32'(arr_we),    32'(m));
    chk({tag, " write data"},  32'(arr_wdata), 32'(d));
    @(negedge clk);
    chk({tag, " ready after write"}, 32'(req_ready), 32'd1);
    chk({tag, " we after write"},    32'(arr_we),    32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int stall, input string tag);
    logic [DW-1:0] exp;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_wmask = DW'($urandom_range(0, 255));
    req_wdata = DW'($urandom_range(0, 255));
    rsp_ready = (stall == 0);
    wait_ready(tag);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = AW'($urandom_range(0, WORDS - 1));
    // READ cycle: array addressed, no write, response not yet up.
    chk({tag, " read-cycle valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " read addr"},        32'(arr_idx),   32'(a));
    chk({tag, " read we"},          32'(arr_we),    32'd0);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp));
    chk({tag, " ready in resp"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, " stall hold"}, {22'd0, rsp_valid, req_ready, rsp_rdata}, {22'd0, 1'b1, 1'b0, exp});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, " rsp dropped"},      32'(rsp_valid), 32'd0);
    chk({tag, " ready after resp"}, 32'(req_ready), 32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] mask;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reads after the sweep, full and masked writes, corner addresses.
    vecs[0]  = '{1'b0, 9'h000, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 9'h1FF, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 9'h0A5, 8'h00, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 9'h0A5, 8'hFF, 8'h3C, 8'h00};
    vecs[4]  = '{1'b0, 9'h0A5, 8'h00, 8'h00, 8'h3C};
    vecs[5]  = '{1'b1, 9'h0A5, 8'h0F, 8'hFF, 8'h00};
    vecs[6]  = '{1'b0, 9'h0A5, 8'h00, 8'h00, 8'h3F};
    vecs[7]  = '{1'b1, 9'h000, 8'hFF, 8'h11, 8'h00};
    vecs[8]  = '{1'b1, 9'h1FF, 8'hFF, 8'h22, 8'h00};
    vecs[9]  = '{1'b0, 9'h000, 8'h00, 8'h00, 8'h11};
    vecs[10] = '{1'b0, 9'h1FF, 8'h00, 8'h00, 8'h22};
    vecs[11] = '{1'b1, 9'h123, 8'hF0, 8'h5A, 8'h00};
    vecs[12] = '{1'b0, 9'h123, 8'h00, 8'h00, 8'h50};
    vecs[13] = '{1'b1, 9'h123, 8'h0F, 8'h5A, 8'h00};
    vecs[14] = '{1'b0, 9'h123, 8'h00, 8'h00, 8'h5A};
    vecs[15] = '{1'b0, 9'h0A5, 8'h00, 8'h00, 8'h3F};

    // Reset held: everything quiet, FSM parked in INIT.
    repeat (3) @(negedge clk);
    chk("reset state",     32'(state_dbg), 32'(S_INIT));
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset init_done", 32'(init_done), 32'd0);
    chk("reset arr_we",    32'(arr_we),    32'd0);
    rst = 1'b1;
    wait_init("init1");

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) begin
        do_write(vecs[i].addr, vecs[i].mask, vecs[i].data, $sformatf("vec%0d", i));
      end else begin
        exp_q.push_back(vecs[i].exp);
        do_read(vecs[i].addr, 0, $sformatf("vec%0d", i));
      end
    end

    // Back-pressured read: response held for 5 cycles.
    exp_q.push_back(8'h3F);
    do_read(9'h0A5, 5, "stall");

    // Reset while a response is pending.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 9'h123;
    rsp_ready = 1'b0;
    wait_ready("rst-in-resp");
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    chk("pre-reset rsp_rdata", 32'(rsp_rdata), 32'h5A);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async reset state",     32'(state_dbg), 32'(S_INIT));
    chk("async reset init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_init("init2");

    exp_q.push_back(8'h00);
    do_read(9'h123, 0, "post-reset 0x123");
    exp_q.push_back(8'h00);
    do_read(9'h1FF, 0, "post-reset 0x1FF");
    exp_q.push_back(8'h00);
    do_read(9'h0A5, 0, "post-reset 0x0A5");

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
